// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters feeding a registered 4:1 data select.
// A grant is held until the downstream handshake, then passes to the next requester in rotation.
module mux4_rr_arbiter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         dbg_state_o
);

  // Handshake: a beat transfers on a posedge where out_valid=1 and out_ready=1;
  // until then gnt/sel/y stay stable, whatever req does.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [2:0] pick;

  // Returns {found, index}: first set bit of r searched from base+1 round to base.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    pick    = '0;
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[2]) begin
          state_d = GRANT;
          sel_d   = pick[1:0];
          gnt_d   = 4'b0001 << pick[1:0];
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (valid_q && out_ready) begin
          ptr_d = sel_q;
          // The requester just served is masked so others get a turn first.
          pick  = rr_pick(req & ~(4'b0001 << sel_q), sel_q);
          if (pick[2]) begin
            sel_d = pick[1:0];
            gnt_d = 4'b0001 << pick[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    y = '0;
    if (valid_q) begin
      case (sel_q)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign out_valid   = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: each step queues the expected {out_valid, sel}
// and checks grant, data and state invariants one cycle later.
module tb_mux4_rr_arbiter;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] d [4];
  logic         out_ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic         out_valid;
  logic         dbg_state;

  logic [2:0]   exp_q[$];
  int           checks;
  int           errors;
  logic         fix_d2;

  mux4_rr_arbiter #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .d0          (d[0]),
    .d1          (d[1]),
    .d2          (d[2]),
    .d3          (d[3]),
    .out_ready   (out_ready),
    .gnt         (gnt),
    .sel         (sel),
    .y           (y),
    .out_valid   (out_valid),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outcome, then check after the edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic rdy,
                      input logic ev, input logic [1:0] es);
    logic [2:0]   e;
    logic [3:0]   exp_gnt;
    logic [W-1:0] exp_y;
    @(negedge clk);
    reset     = rst;
    req       = r;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, (1 << W) - 1));
    if (fix_d2) d[2] = 5'b00100;
    exp_q.push_back({ev, es});
    @(posedge clk);
    #1;
    e       = exp_q.pop_front();
    exp_gnt = e[2] ? (4'b0001 << e[1:0]) : 4'b0000;
    exp_y   = e[2] ? d[e[1:0]] : '0;
    chk("out_valid", 32'(out_valid), 32'(e[2]));
    chk("sel", 32'(sel), 32'(e[1:0]));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("y", 32'(y), 32'(exp_y));
    chk("state", 32'(dbg_state), 32'(e[2]));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    fix_d2    = 1'b0;
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset state, then full request set rotating 0,1,2,3,0.
    step(1, 4'b1111, 1, 0, 2'd0);
    step(0, 4'b1111, 1, 1, 2'd0);
    step(0, 4'b1111, 1, 1, 2'd1);
    step(0, 4'b1111, 1, 1, 2'd2);
    step(0, 4'b1111, 1, 1, 2'd3);
    step(0, 4'b1111, 1, 1, 2'd0);
    step(0, 4'b0000, 1, 0, 2'd0);

    // Stalled grant of requester 2 held for four cycles, req changes ignored.
    fix_d2 = 1'b1;
    step(0, 4'b0100, 0, 1, 2'd2);
    chk("y_d2", 32'(y), 32'd4);
    step(0, 4'b0100, 0, 1, 2'd2);
    step(0, 4'b0000, 0, 1, 2'd2);
    step(0, 4'b1011, 0, 1, 2'd2);
    chk("y_d2_hold", 32'(y), 32'd4);
    step(0, 4'b0100, 1, 0, 2'd2);
    fix_d2 = 1'b0;

    // Wrap-around from ptr=3 after reset: 0 then 3.
    step(1, 4'b0000, 0, 0, 2'd0);
    step(0, 4'b1001, 1, 1, 2'd0);
    step(0, 4'b1001, 1, 1, 2'd3);
    step(0, 4'b0000, 1, 0, 2'd3);

    // Lone requester 1: a bubble after each beat.
    step(0, 4'b0010, 1, 1, 2'd1);
    step(0, 4'b0010, 1, 0, 2'd1);
    step(0, 4'b0010, 1, 1, 2'd1);
    step(0, 4'b0010, 1, 0, 2'd1);

    // Reset mid-grant during a handshake; held reset ignores req, then 0 wins.
    step(0, 4'b1111, 1, 1, 2'd2);
    step(1, 4'b1111, 1, 0, 2'd0);
    step(1, 4'b1111, 1, 0, 2'd0);
    step(0, 4'b1111, 1, 1, 2'd0);
    step(0, 4'b1010, 1, 1, 2'd1);
    step(0, 4'b1010, 1, 1, 2'd3);
    step(0, 4'b1010, 0, 1, 2'd3);
    step(0, 4'b1010, 1, 1, 2'd1);
    step(0, 4'b0000, 1, 0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: W, default 5, data width of each requester channel and of y.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester request; bit i = requester i.
REQ-005 Port: d0, d1, d2, d3  input  W each  requester data.
REQ-006 Port: out_ready  input  1  downstream accepts y this cycle.
REQ-007 Port: gnt  output  4  one-hot grant, registered; all zero when no grant.
REQ-008 Port: sel  output  2  index of granted requester, registered; drives the 4:1 data select.
REQ-009 Port: y  output  W  selected data: d[sel] when out_valid=1, else all zero; combinational from d0..d3.
REQ-010 Port: out_valid  output  1  y holds a valid beat; registered.

Function
REQ-011 FSM has two states: IDLE (no grant) and GRANT (one requester owns the output).
REQ-012 Round-robin pointer ptr (2 bits) = index of last requester served; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-013 IDLE: if req != 0, then on the next posedge: state=GRANT; sel=first asserted index in search order; gnt=one-hot(sel); out_valid=1. Latency from req to grant is 1 cycle.
REQ-014 IDLE with req == 0: state, gnt, sel and out_valid hold their IDLE values.
REQ-015 GRANT: gnt, sel and out_valid hold until handshake (out_valid=1 and out_ready=1 in the same cycle); changes to req[sel] are ignored while out_ready=0.
REQ-016 On handshake: ptr<=sel; the next grant is chosen in the same edge from the current req with bit sel masked out, searched from sel+1.
REQ-017 On handshake, if the masked req is nonzero, GRANT continues back-to-back with no bubble; otherwise state=IDLE, gnt=0, out_valid=0.
REQ-018 The masked req excludes the requester just served, so any single requester gets at most one beat per handshake while others wait; a lone requester is re-granted only after a one-cycle IDLE bubble.
REQ-019 Wrap-around: ptr=3 searches 0,1,2,3; ptr arithmetic is modulo 4.
REQ-020 sel is set only in the cycle a grant is issued; it holds its value through IDLE.
REQ-021 Under continuous requests, every asserting requester is granted within 4 handshakes (no starvation).
REQ-022 At most one gnt bit is set in any cycle, and gnt != 0 if and only if out_valid=1.

Reset
REQ-023 reset=1 at posedge: state=IDLE, gnt=0, sel=0, out_valid=0, ptr=3, so requester 0 has first priority after reset.
REQ-024 Reset overrides any in-progress grant, including one in the same cycle as a handshake; the beat is dropped and no ptr update occurs.
REQ-025 Outputs take their reset values from the first posedge with reset=1 and hold them while reset stays high, regardless of req and out_ready.

Verification
REQ-026 Reset, then req=4'b1111, out_ready=1 for 5 cycles -> grants 0,1,2,3,0 on consecutive cycles; y=d0,d1,d2,d3,d0.
REQ-027 req=4'b0100, d2=5'b00100, out_ready=0 for 3 cycles, then 1 -> gnt=4'b0100, sel=2'b10, y=5'b00100 held 4 cycles; state=IDLE after handshake.
REQ-028 ptr=3, req=4'b1001, out_ready=1 -> requester 0 granted first, then requester 3 (wrap-around order).
REQ-029 Lone req=4'b0010 held high, out_ready=1 -> out_valid pattern 1,0,1,0 (bubble after each beat).
REQ-030 reset asserted during GRANT with out_ready=1 -> next cycle gnt=0, out_valid=0, y=0; next req=4'b1111 grants requester 0.
REQ-031 Every test: assert gnt is one-hot or zero, gnt != 0 if and only if out_valid=1, and y equals d[sel] whenever out_valid=1.
